seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Full hex decode (0-F), per-digit decimal point and blanking, optional leading-zero suppression, and configurable segment/anode polarity.
- Includes anti-ghosting guard time and tear-free frame-synchronous value update with load/ack.
- Sits between the status/debug logic (e.g. frame counters, register readback) and board display pins.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_scan_driver_if.sv | 35 +++
 rtl/seg7_hex_lut.sv | 13 +
 rtl/seg7_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   seg_t      : active-high segment pattern {g,f,e,d,c,b,a}
//   SEG_TABLE  : hex digit 0..F to active-high segment pattern
//   SEG_OFF    : active-high pattern with every segment dark
//   idx_width  : width of a digit index for n digits (never below 1)
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  localparam seg_t SEG_OFF = 7'h00;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the status/debug logic (master) and the scan driver (slave).
//   value_i : 4*NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp_i    : decimal point per digit
//   blank_i : force digit dark
//   load_i  : capture value_i/dp_i/blank_i into the shadow
//   ack_o   : one-cycle pulse when the shadow reaches the display
//   frame_o : one-cycle pulse after each frame boundary
//   seg_o   : segment pins {g,f,e,d,c,b,a}, dp_o decimal point pin
//   an_o    : digit enable pins
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic                    load_i;
  logic                    ack_o;
  logic                    frame_o;
  seg_t                    seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   an_o;

  modport master (
    output value_i, dp_i, blank_i, load_i,
    input  ack_o, frame_o, seg_o, dp_o, an_o
  );

  modport slave (
    input  value_i, dp_i, blank_i, load_i,
    output ack_o, frame_o, seg_o, dp_o, an_o
  );

endinterface

// File: rtl/seg7_hex_lut.sv
// Hex nibble to active-high 7-segment pattern (pure combinational).
//   nibble : hex digit 0..F
//   seg    : active-high {g,f,e,d,c,b,a}
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment digits on one segment bus.
// Each digit owns a slot of SCAN_DIV clocks; the first GUARD clocks of a slot
// keep every anode off so the previous digit's pattern cannot ghost. New values
// go into a shadow via load_i and are committed to the display only at the
// frame boundary, so a frame never mixes old and new digits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of seg7_scan_driver_if (inputs, handshake, pins)
// All pin outputs are registered and reflect the previous cycle's state.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GUARD_C  = DW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Pin levels for "dark" in the configured polarity.
  localparam seg_t                  SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_ACT_LOW}};

  logic [DW-1:0]         div_reg;
  logic [IW-1:0]         idx_reg;
  logic [VW-1:0]         shadow_val_reg, disp_val_reg;
  logic [NUM_DIGITS-1:0] shadow_dp_reg, disp_dp_reg;
  logic [NUM_DIGITS-1:0] shadow_blank_reg, disp_blank_reg;
  logic                  pending_reg;

  seg_t                  seg_reg;
  logic                  dp_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic                  ack_reg;
  logic                  frame_reg;

  logic                  slot_last;
  logic                  boundary;
  logic                  commit;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] an_act;
  seg_t                  lut_seg;
  seg_t                  seg_next;
  logic                  dp_next;

  assign slot_last = (div_reg == DIV_LAST);
  assign boundary  = slot_last && (idx_reg == IDX_LAST);
  // A load on the boundary cycle itself is committed straight from the inputs.
  assign commit    = boundary && (pending_reg || bus.load_i);

  // Digit gi is a leading zero when it and every nibble above it are zero.
  // Digit 0 is never suppressed so a zero value still shows "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_mask[gi] = 1'b0;
      end else begin : g_upper
        assign lz_mask[gi] = LZ_SUPPRESS && (disp_val_reg[VW-1:4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    an_act    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_nib   = disp_val_reg[4*i +: 4];
        cur_dp    = disp_dp_reg[i];
        cur_blank = disp_blank_reg[i];
        cur_lz    = lz_mask[i];
        an_act[i] = (div_reg >= GUARD_C);
      end
    end
  end

  seg7_hex_lut u_lut (
    .nibble (cur_nib),
    .seg    (lut_seg)
  );

  // Blanking darkens dp too; suppression only darkens the segments.
  assign seg_next = (cur_blank || cur_lz) ? SEG_OFF : lut_seg;
  assign dp_next  = cur_dp && !cur_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg          <= '0;
      idx_reg          <= '0;
      shadow_val_reg   <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      disp_val_reg     <= '0;
      disp_dp_reg      <= '0;
      disp_blank_reg   <= '0;
      pending_reg      <= 1'b0;
    end else begin
      div_reg <= slot_last ? '0 : div_reg + 1'b1;
      if (slot_last) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end

      if (bus.load_i) begin
        shadow_val_reg   <= bus.value_i;
        shadow_dp_reg    <= bus.dp_i;
        shadow_blank_reg <= bus.blank_i;
      end

      if (commit) begin
        disp_val_reg   <= bus.load_i ? bus.value_i : shadow_val_reg;
        disp_dp_reg    <= bus.load_i ? bus.dp_i    : shadow_dp_reg;
        disp_blank_reg <= bus.load_i ? bus.blank_i : shadow_blank_reg;
        pending_reg    <= 1'b0;
      end else if (bus.load_i) begin
        pending_reg    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg   <= SEG_IDLE;
      dp_reg    <= SEG_ACT_LOW;
      an_reg    <= AN_IDLE;
      ack_reg   <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      seg_reg   <= SEG_ACT_LOW ? ~seg_next : seg_next;
      dp_reg    <= dp_next ^ SEG_ACT_LOW;
      an_reg    <= an_act ^ AN_IDLE;
      ack_reg   <= commit;
      frame_reg <= boundary;
    end
  end

  assign bus.seg_o   = seg_reg;
  assign bus.dp_o    = dp_reg;
  assign bus.an_o    = an_reg;
  assign bus.ack_o   = ack_reg;
  assign bus.frame_o = frame_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (4 digits, 8-clock
// slots, guard 2, active-low pins, leading-zero suppression). A reference
// model derives slot/digit from a plain cycle count and keeps the committed
// display, shadow and pending flag as ordinary variables.
module tb_seg7_scan_driver;

  localparam int ND   = 4;
  localparam int DIV  = 8;
  localparam int GRD  = 2;
  localparam int FRM  = ND * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (DIV),
    .GUARD       (GRD),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1),
    .LZ_SUPPRESS (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  int          n;          // clock edges since reset release
  logic [15:0] m_val, sh_val;
  logic [3:0]  m_dp, sh_dp, m_blank, sh_blank;
  bit          pend;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (model cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_val = '0; m_dp = '0; m_blank = '0;
    sh_val = '0; sh_dp = '0; sh_blank = '0;
    pend = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".seg"},   16'(bus.seg_o),   16'h007F);
    check({tag, ".dp"},    16'(bus.dp_o),    16'h0001);
    check({tag, ".an"},    16'(bus.an_o),    16'h000F);
    check({tag, ".ack"},   16'(bus.ack_o),   16'h0000);
    check({tag, ".frame"}, 16'(bus.frame_o), 16'h0000);
  endtask

  // One clock: drive inputs, predict the pins from the pre-edge model state,
  // clock, advance the model, compare.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    int         slot_pos, digit;
    logic [15:0] upper;
    logic [6:0] seg_ah;
    logic [6:0] e_seg;
    logic       e_dp, e_ack, e_frame, bnd;
    logic [3:0] e_an, onehot;

    bus.load_i  = ld;
    bus.value_i = v;
    bus.dp_i    = d;
    bus.blank_i = b;
    if (ld) $display("load value=%h dp=%b blank=%b at model cycle %0d", v, d, b, n);

    slot_pos = n % DIV;
    digit    = (n / DIV) % ND;
    upper    = m_val >> (4 * digit);
    if (m_blank[digit])               seg_ah = 7'h00;
    else if (digit > 0 && upper == 0) seg_ah = 7'h00;
    else                              seg_ah = hex_tab[upper[3:0]];
    e_seg   = ~seg_ah;
    e_dp    = ~(m_dp[digit] & ~m_blank[digit]);
    onehot  = 4'b0001 << digit;
    e_an    = (slot_pos >= GRD) ? ~onehot : 4'hF;
    bnd     = (n % FRM) == FRM - 1;
    e_ack   = bnd && (ld || pend);
    e_frame = bnd;

    @(posedge clk);
    #1;
    if (ld) begin
      sh_val = v; sh_dp = d; sh_blank = b; pend = 1'b1;
    end
    if (bnd && pend) begin
      m_val = sh_val; m_dp = sh_dp; m_blank = sh_blank; pend = 1'b0;
    end
    n++;

    check("seg",   16'(bus.seg_o),   16'(e_seg));
    check("dp",    16'(bus.dp_o),    16'(e_dp));
    check("an",    16'(bus.an_o),    16'(e_an));
    check("ack",   16'(bus.ack_o),   16'(e_ack));
    check("frame", 16'(bus.frame_o), 16'(e_frame));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++)
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1;
    check_idle("held_rst");
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.load_i  = 1'b0;
    bus.value_i = '0;
    bus.dp_i    = '0;
    bus.blank_i = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    run(70);                                      // idle: "0" on digit 0 only
    cycle(1'b1, 16'h12AF, 4'b0010, 4'b0000);
    run(80);
    cycle(1'b1, 16'h0050, 4'b0000, 4'b0000);
    run(70);
    cycle(1'b1, 16'h0000, 4'b0000, 4'b0001);      // everything dark
    run(70);

    while (n % FRM != 5) run(1);                  // two loads in one frame
    cycle(1'b1, 16'h1111, 4'b0000, 4'b0000);
    run(10);
    cycle(1'b1, 16'h2222, 4'b0000, 4'b0000);
    run(60);

    while (n % FRM != FRM - 1) run(1);            // load on the boundary cycle
    cycle(1'b1, 16'h3333, 4'b0101, 4'b0000);
    run(40);

    cycle(1'b1, 16'hABCD, 4'b0000, 4'b0000);
    run(40);
    cycle(1'b1, 16'h5555, 4'b0000, 4'b0000);      // left pending across reset
    run(3);
    do_reset();
    run(70);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle(($urandom_range(0, 15) == 0), 16'($urandom),
                 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
